// File: rtl/gamma_pkg.sv
// gamma_pkg: shared helpers for gamma-domain spike blocks.
// Time-stamp sizing, bank count and small arithmetic helpers.
package gamma_pkg;

  function automatic int tw_of(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

  function automatic int nbank_of(input int depth);
    return depth + 1;
  endfunction

  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned sat_inc(
    input int unsigned v,
    input int unsigned max
  );
    return (v >= max) ? max : v + 1;
  endfunction

  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) n += {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/gamma_timer.sv
// gamma_timer: saturating in-cycle time, bank write/read pointers
// and the armed flag for the spike replay memory.
module gamma_timer
  import gamma_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int DEPTH = 1,
  localparam int TW = tw_of(GAMMA_CYCLE_WIDTH),
  localparam int NBANK = nbank_of(DEPTH),
  localparam int BW = ptr_w(NBANK)
) (
  input  logic          aclk,
  input  logic          rst,
  input  logic          grst,
  output logic [TW-1:0] t,
  output logic [BW-1:0] wp,
  output logic [BW-1:0] wp_e,
  output logic [BW-1:0] rp,
  output logic          armed
);

  localparam int unsigned TMAX = GAMMA_CYCLE_WIDTH - 1;
  localparam logic [BW-1:0] LAST = BW'(NBANK - 1);

  logic [TW-1:0] t_reg;

  function automatic logic [BW-1:0] wrap_inc(
    input logic [BW-1:0] p
  );
    return (p == LAST) ? '0 : p + BW'(1);
  endfunction

  always_comb begin
    t    = grst ? '0 : t_reg;
    wp_e = grst ? wrap_inc(wp) : wp;
    rp   = wrap_inc(wp_e);
  end

  // A late or missing grst parks t at its maximum instead of wrapping.
  always_ff @(posedge aclk) begin
    if (rst) begin
      t_reg <= TW'(TMAX);
      wp    <= '0;
      armed <= 1'b0;
    end else begin
      t_reg <= TW'(sat_inc(32'(t), TMAX));
      wp    <= wp_e;
      if (grst) armed <= 1'b1;
    end
  end

endmodule

// File: rtl/gamma_spike_replay.sv
// gamma_spike_replay: records first spike times per gamma cycle and
// replays them as fixed-width pulses DEPTH gamma cycles later.
module gamma_spike_replay
  import gamma_pkg::*;
#(
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH = 8,
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic                       aclk,
  input  logic                       rst,
  input  logic                       grst,
  input  logic [WIDTH-1:0]           in,
  input  logic                       wta_en,
  input  logic                       replay_en,
  output logic [WIDTH-1:0]           out,
  output logic [$clog2(WIDTH+1)-1:0] rec_count,
  output logic                       armed
);

  localparam int TW = tw_of(GAMMA_CYCLE_WIDTH);
  localparam int NBANK = nbank_of(DEPTH);
  localparam int BW = ptr_w(NBANK);
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam int CW = TW + $clog2(PULSE_WIDTH) + 1;

  logic [TW-1:0]    t;
  logic [BW-1:0]    wp;
  logic [BW-1:0]    wp_e;
  logic [BW-1:0]    rp;
  logic [WIDTH-1:0] in_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] first;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] rec;
  logic [WIDTH-1:0] out_nx;
  logic [WIDTH-1:0] vld [NBANK];
  logic [TW-1:0]    ts [NBANK][WIDTH];
  logic             wta_q;
  logic             wta_done;
  logic             wta_m;
  logic             done_e;

  gamma_timer #(
    .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH),
    .DEPTH(DEPTH)
  ) u_timer (
    .aclk(aclk),
    .rst(rst),
    .grst(grst),
    .t(t),
    .wp(wp),
    .wp_e(wp_e),
    .rp(rp),
    .armed(armed)
  );

  assign rise  = in & ~in_q;
  assign first = rise & (~rise + WIDTH'(1));

  // The bank being entered is treated as empty in its grst cycle.
  always_comb begin
    wta_m  = grst ? wta_en : wta_q;
    done_e = grst ? 1'b0 : wta_done;
    base   = grst ? '0 : vld[wp_e];
    rec    = '0;
    if (armed) begin
      if (wta_m) rec = done_e ? '0 : first;
      else       rec = rise & ~base;
    end
  end

  always_comb begin
    out_nx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      out_nx[i] = armed & replay_en & vld[rp][i]
        & (CW'(t) >= CW'(ts[rp][i]))
        & (CW'(t) < CW'(ts[rp][i]) + CW'(PULSE_WIDTH));
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      in_q      <= '0;
      out       <= '0;
      rec_count <= '0;
      wta_q     <= 1'b0;
      wta_done  <= 1'b0;
      for (int b = 0; b < NBANK; b++) vld[b] <= '0;
    end else begin
      in_q      <= in;
      out       <= out_nx;
      vld[wp_e] <= base | rec;
      wta_done  <= done_e | (armed & wta_m & (|rise));
      if (grst) begin
        wta_q     <= wta_en;
        rec_count <= CNTW'(popcount(64'(vld[wp])));
      end
    end
  end

  always_ff @(posedge aclk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (!rst && rec[i]) ts[wp_e][i] <= t;
    end
  end

endmodule

// File: tb/tb_gamma_spike_replay.sv
// tb_gamma_spike_replay: directed and random checks of the spike
// replay memory at DEPTH=1 and DEPTH=2 against a gamma-cycle model.
module tb_gamma_spike_replay;

  logic       aclk = 1'b0;
  logic       rst;
  logic       grst;
  logic [7:0] in;
  logic       wta_en;
  logic       replay_en;
  logic [7:0] out1;
  logic [7:0] out2;
  logic [3:0] cnt1;
  logic [3:0] cnt2;
  logic       armed1;
  logic       armed2;

  always #5 aclk = ~aclk;

  gamma_spike_replay #(.DEPTH(1)) d1 (
    .aclk(aclk), .rst(rst), .grst(grst), .in(in),
    .wta_en(wta_en), .replay_en(replay_en),
    .out(out1), .rec_count(cnt1), .armed(armed1)
  );

  gamma_spike_replay #(.DEPTH(2)) d2 (
    .aclk(aclk), .rst(rst), .grst(grst), .in(in),
    .wta_en(wta_en), .replay_en(replay_en),
    .out(out2), .rec_count(cnt2), .armed(armed2)
  );

  int n_tests = 0;
  int n_fail = 0;

  // Model: per gamma cycle, the first time each line spiked (-1 = none).
  typedef int rec_t[8];
  rec_t       hist[$];
  rec_t       cur;
  bit         m_armed;
  bit         m_wta;
  bit         m_taken;
  int         m_t;
  logic [7:0] m_prev;
  logic [7:0] e_out1;
  logic [7:0] e_out2;
  logic [3:0] e_cnt;
  bit         e_armed;
  int         st[8];

  function automatic logic [3:0] cnt_of(input rec_t r);
    logic [3:0] n;
    n = 0;
    for (int j = 0; j < 8; j++) if (r[j] >= 0) n++;
    return n;
  endfunction

  function automatic logic [7:0] replay_of(input int d, input int tn, input bit re);
    logic [7:0] o;
    rec_t s;
    o = 0;
    if (!m_armed || !re || hist.size() < d) return o;
    s = hist[hist.size() - d];
    for (int j = 0; j < 8; j++)
      if (s[j] >= 0 && tn >= s[j] && tn < s[j] + 8) o[j] = 1'b1;
    return o;
  endfunction

  function automatic bit win(input int c, input int t0);
    return c >= t0 && c < t0 + 8;
  endfunction

  function automatic logic [7:0] pat(input int c);
    logic [7:0] v;
    v = 0;
    for (int j = 0; j < 8; j++)
      if (st[j] >= 0 && c >= st[j] && c <= st[j] + 2) v[j] = 1'b1;
    return v;
  endfunction

  task automatic clear_st();
    for (int j = 0; j < 8; j++) st[j] = -1;
  endtask

  task automatic tick(input bit r, input bit g, input logic [7:0] v,
                      input bit w, input bit re);
    int tn;
    logic [7:0] rise;
    rst = r; grst = g; in = v; wta_en = w; replay_en = re;
    if (r) begin
      m_armed = 0;
      hist.delete();
      for (int j = 0; j < 8; j++) cur[j] = -1;
      m_t = 15;
      m_prev = '0;
      e_out1 = '0;
      e_out2 = '0;
      e_cnt = '0;
    end else begin
      if (g) begin
        e_cnt = cnt_of(cur);
        hist.push_back(cur);
        for (int j = 0; j < 8; j++) cur[j] = -1;
        m_wta = w;
        m_taken = 0;
      end
      tn = g ? 0 : m_t;
      rise = v & ~m_prev;
      if (m_armed) begin
        for (int j = 0; j < 8; j++)
          if (rise[j] && cur[j] < 0 && !(m_wta && m_taken)) begin
            cur[j] = tn;
            if (m_wta) m_taken = 1;
          end
      end
      e_out1 = replay_of(1, tn, re);
      e_out2 = replay_of(2, tn, re);
      if (g) m_armed = 1;
      m_t = (tn < 15) ? tn + 1 : 15;
      m_prev = v;
    end
    e_armed = m_armed;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) tick(1, 0, 8'hff, 0, 1);
    n_tests++;
    if (out1 !== 8'h00 || out2 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out got %h %h want 00 00", out1, out2);
    end
    n_tests++;
    if (cnt1 !== 4'd0 || armed1 !== 1'b0 || armed2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state cnt=%0d armed=%b%b want 0 00", cnt1, armed1, armed2);
    end
    for (int c = 0; c < 16; c++) begin
      tick(0, c == 0, 8'h00, 0, 1);
      n_tests++;
      if (armed1 !== 1'b1 || armed2 !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_arm c=%0d armed=%b%b want 11", c, armed1, armed2);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] ex;
    for (int g = 0; g < 3; g++) begin
      clear_st();
      if (g == 0) begin st[2] = 1; st[5] = 2; st[0] = 4; st[6] = 6; end
      for (int c = 0; c < 16; c++) begin
        tick(0, c == 0, pat(c), 0, 1);
        n_tests++;
        if ({out1, out2, cnt1, cnt2, armed1, armed2} !==
            {e_out1, e_out2, e_cnt, e_cnt, e_armed, e_armed}) begin
          n_fail++;
          $display("FAIL basic_model g=%0d c=%0d got %h %h %0d %0d want %h %h %0d",
                   g, c, out1, out2, cnt1, cnt2, e_out1, e_out2, e_cnt);
        end
        ex = 0;
        ex[2] = win(c, 1); ex[5] = win(c, 2); ex[0] = win(c, 4); ex[6] = win(c, 6);
        if (g == 1) begin
          n_tests++;
          if (out1 !== ex) begin
            n_fail++;
            $display("FAIL basic_d1 c=%0d out=%h want %h", c, out1, ex);
          end
        end
        if (g == 2) begin
          n_tests++;
          if (out2 !== ex || out1 !== 8'h00) begin
            n_fail++;
            $display("FAIL basic_d2 c=%0d out2=%h out1=%h want %h 00", c, out2, out1, ex);
          end
        end
        if (g == 1 && c == 0) begin
          n_tests++;
          if (cnt1 !== 4'd4) begin
            n_fail++;
            $display("FAIL basic_count got %0d want 4", cnt1);
          end
        end
      end
    end
  endtask

  task automatic test_clip();
    for (int g = 0; g < 3; g++) begin
      clear_st();
      if (g == 0) st[7] = 12;
      for (int c = 0; c < 16; c++) begin
        tick(0, c == 0, pat(c), 0, 1);
        n_tests++;
        if ({out1, out2, cnt1, cnt2} !== {e_out1, e_out2, e_cnt, e_cnt}) begin
          n_fail++;
          $display("FAIL clip_model g=%0d c=%0d got %h %h %0d want %h %h %0d",
                   g, c, out1, out2, cnt1, e_out1, e_out2, e_cnt);
        end
        if (g == 1 || (g == 2 && c == 0)) begin
          n_tests++;
          if (out1[7] !== (g == 1 && c >= 12)) begin
            n_fail++;
            $display("FAIL clip_d1 g=%0d c=%0d out7=%b want %b", g, c, out1[7], g == 1 && c >= 12);
          end
        end
      end
    end
  endtask

  task automatic test_wta();
    bit w;
    for (int g = 0; g < 4; g++) begin
      clear_st();
      if (g == 0) begin st[3] = 2; st[4] = 5; st[1] = 5; end
      if (g == 1 || g == 2) begin st[4] = 5; st[1] = 5; end
      for (int c = 0; c < 16; c++) begin
        w = (g < 2) ? (c == 0) : (g == 2 && c != 0);
        tick(0, c == 0, pat(c), w, 1);
        n_tests++;
        if ({out1, out2, cnt1, cnt2} !== {e_out1, e_out2, e_cnt, e_cnt}) begin
          n_fail++;
          $display("FAIL wta_model g=%0d c=%0d got %h %h %0d want %h %h %0d",
                   g, c, out1, out2, cnt1, e_out1, e_out2, e_cnt);
        end
        if (g == 1) begin
          n_tests++;
          if (out1 !== (win(c, 2) ? 8'h08 : 8'h00)) begin
            n_fail++;
            $display("FAIL wta_tie3 c=%0d out=%h want %h", c, out1, win(c, 2) ? 8'h08 : 8'h00);
          end
        end
        if (g == 2) begin
          n_tests++;
          if (out1 !== (win(c, 5) ? 8'h02 : 8'h00)) begin
            n_fail++;
            $display("FAIL wta_low c=%0d out=%h want %h", c, out1, win(c, 5) ? 8'h02 : 8'h00);
          end
        end
        if (c == 0 && g > 0) begin
          n_tests++;
          if (cnt1 !== ((g == 3) ? 4'd2 : 4'd1)) begin
            n_fail++;
            $display("FAIL wta_count g=%0d got %0d want %0d", g, cnt1, (g == 3) ? 2 : 1);
          end
        end
      end
    end
  endtask

  task automatic test_level();
    for (int g = 0; g < 3; g++) begin
      clear_st();
      if (g == 0) st[0] = 13;
      if (g == 1) begin st[0] = 0; st[1] = 0; end
      for (int c = 0; c < 16; c++) begin
        tick(0, c == 0, pat(c), 0, 1);
        n_tests++;
        if ({out1, out2, cnt1, cnt2} !== {e_out1, e_out2, e_cnt, e_cnt}) begin
          n_fail++;
          $display("FAIL level_model g=%0d c=%0d got %h %h %0d want %h %h %0d",
                   g, c, out1, out2, cnt1, e_out1, e_out2, e_cnt);
        end
        if (g == 2) begin
          n_tests++;
          if (out1 !== (win(c, 0) ? 8'h02 : 8'h00)) begin
            n_fail++;
            $display("FAIL level_d1 c=%0d out=%h want %h", c, out1, win(c, 0) ? 8'h02 : 8'h00);
          end
        end
        if (g == 2 && c == 0) begin
          n_tests++;
          if (cnt1 !== 4'd1) begin
            n_fail++;
            $display("FAIL level_count got %0d want 1", cnt1);
          end
        end
      end
    end
  endtask

  task automatic test_gate();
    logic [7:0] v;
    logic [7:0] ex;
    for (int g = 0; g < 3; g++) begin
      for (int c = 0; c < 16; c++) begin
        v = (g == 0 && (c == 2 || c == 4 || c == 5)) ? 8'h08 : 8'h00;
        tick(0, c == 0, v, 0, !(g == 1 && c >= 5));
        n_tests++;
        if ({out1, out2, cnt1, cnt2} !== {e_out1, e_out2, e_cnt, e_cnt}) begin
          n_fail++;
          $display("FAIL gate_model g=%0d c=%0d got %h %h %0d want %h %h %0d",
                   g, c, out1, out2, cnt1, e_out1, e_out2, e_cnt);
        end
        if (g == 1) begin
          ex = (win(c, 2) && c < 5) ? 8'h08 : 8'h00;
          n_tests++;
          if (out1 !== ex) begin
            n_fail++;
            $display("FAIL gate_cut c=%0d out=%h want %h", c, out1, ex);
          end
        end
        if (g == 2) begin
          ex = win(c, 2) ? 8'h08 : 8'h00;
          n_tests++;
          if (out2 !== ex) begin
            n_fail++;
            $display("FAIL gate_first c=%0d out2=%h want %h", c, out2, ex);
          end
        end
      end
    end
  endtask

  task automatic test_depth2();
    logic [7:0] ex;
    for (int g = 0; g < 7; g++) begin
      clear_st();
      if (g == 1 || g == 4) st[2] = 3;
      for (int c = 0; c < 16; c++) begin
        tick(g == 5 && c == 6, c == 0, pat(c), 0, 1);
        n_tests++;
        if ({out1, out2, cnt1, cnt2, armed1, armed2} !==
            {e_out1, e_out2, e_cnt, e_cnt, e_armed, e_armed}) begin
          n_fail++;
          $display("FAIL depth2_model g=%0d c=%0d got %h %h %0d %b want %h %h %0d %b",
                   g, c, out1, out2, cnt1, armed2, e_out1, e_out2, e_cnt, e_armed);
        end
        if (g == 2 || g == 3 || g == 6) begin
          ex = (g == 3 && win(c, 3)) ? 8'h04 : 8'h00;
          n_tests++;
          if (out2 !== ex) begin
            n_fail++;
            $display("FAIL depth2_out g=%0d c=%0d out2=%h want %h", g, c, out2, ex);
          end
        end
        if (g == 5 && c >= 6) begin
          n_tests++;
          if (armed2 !== 1'b0 || out1 !== 8'h00) begin
            n_fail++;
            $display("FAIL depth2_rst c=%0d armed=%b out1=%h want 0 00", c, armed2, out1);
          end
        end
        if (g == 6 && c == 0) begin
          n_tests++;
          if (armed2 !== 1'b1 || cnt2 !== 4'd0) begin
            n_fail++;
            $display("FAIL depth2_rearm armed=%b cnt=%0d want 1 0", armed2, cnt2);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int len;
    bit dense;
    bit w;
    logic [7:0] v;
    for (int g = 0; g < 40; g++) begin
      len = int'($urandom_range(12, 20));
      dense = $urandom_range(0, 1) == 1;
      w = $urandom_range(0, 3) == 0;
      clear_st();
      for (int j = 0; j < 8; j++)
        if ($urandom_range(0, 2) != 0) st[j] = int'($urandom_range(0, 15));
      for (int c = 0; c < len; c++) begin
        v = dense ? 8'($urandom & $urandom) : pat(c);
        tick($urandom_range(0, 59) == 0, c == 0, v,
             (c == 0) ? w : ($urandom_range(0, 1) == 1),
             $urandom_range(0, 7) != 0);
        n_tests++;
        if ({out1, out2, cnt1, cnt2, armed1, armed2} !==
            {e_out1, e_out2, e_cnt, e_cnt, e_armed, e_armed}) begin
          n_fail++;
          $display("FAIL random g=%0d c=%0d got %h %h %0d %0d %b want %h %h %0d %b",
                   g, c, out1, out2, cnt1, cnt2, armed1, e_out1, e_out2, e_cnt, e_armed);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_wta();
    test_level();
    test_gate();
    test_depth2();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
